// File: rtl/frame_cfg_pkg.sv
// Shared configuration for the frame strobe generator:
// sync word, command field positions and FSM states.
package frame_cfg_pkg;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

  localparam int COL_MSB    = 31;
  localparam int COL_LSB    = 27;
  localparam int IDX_MSB    = 26;
  localparam int IDX_LSB    = 22;
  localparam int DESYNC_BIT = 20;

  localparam int COL_W = COL_MSB - COL_LSB + 1;
  localparam int IDX_W = IDX_MSB - IDX_LSB + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNCED,
    S_DATA,
    S_STROBE
  } state_e;

endpackage

// File: rtl/frame_strobe_gen_if.sv
// Configuration word stream handshake into the
// frame strobe generator.
interface frame_strobe_gen_if;

  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        WriteReady;

  modport master (
    output WriteData,
    output WriteStrobe,
    input  WriteReady
  );

  modport slave (
    input  WriteData,
    input  WriteStrobe,
    output WriteReady
  );

endinterface

// File: rtl/frame_index_decoder.sv
// Registered binary frame index to one-hot frame
// line decoder with enable.
module frame_index_decoder #(
  parameter int N = 20,
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] idx_i,
  output logic [N-1:0] onehot_o
);

  logic [N-1:0] oh_d, oh_q;

  always_comb begin
    oh_d = '0;
    for (int i = 0; i < N; i++) begin
      oh_d[i] = en_i && (32'(idx_i) == 32'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oh_q <= '0;
    end else begin
      oh_q <= oh_d;
    end
  end

  assign onehot_o = oh_q;

endmodule

// File: rtl/frame_strobe_gen.sv
// Turns a synced configuration word stream into
// per-row data beats and one column/frame strobe.
module frame_strobe_gen
  import frame_cfg_pkg::*;
#(
  parameter int          MaxFramesPerCol  = 20,
  parameter int          FrameSelectWidth = 5,
  parameter int          NumberOfRows     = 16,
  parameter logic [31:0] SyncWord         = SYNC_WORD_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        reset,
  frame_strobe_gen_if.slave           wr,
  output logic [31:0]                 FrameData,
  output logic                        FrameDataValid,
  output logic [FrameSelectWidth-1:0] FrameSelect,
  output logic                        FrameStrobe,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe_O,
  output logic                        Synced,
  output logic                        FrameError
);

  localparam int CntW =
    (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [CntW-1:0] LastRow =
    CntW'(NumberOfRows - 1);

  state_e                      state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [FrameSelectWidth-1:0] sel_q, sel_d;
  logic                        err_q, err_d;
  logic [31:0]                 data_q, data_d;
  logic                        dv_q, dv_d;
  logic                        rdy_q, synced_q, strobe_q;

  logic             accept;
  logic [COL_W-1:0] cmd_col;
  logic [IDX_W-1:0] cmd_idx;
  logic             cmd_desync;
  logic             idx_bad;

  assign accept     = wr.WriteStrobe && rdy_q;
  assign cmd_col    = wr.WriteData[COL_MSB:COL_LSB];
  assign cmd_idx    = wr.WriteData[IDX_MSB:IDX_LSB];
  assign cmd_desync = wr.WriteData[DESYNC_BIT];
  assign idx_bad    =
    32'(cmd_idx) >= 32'(MaxFramesPerCol);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    err_d   = err_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && wr.WriteData == SyncWord) begin
          state_d = S_SYNCED;
        end
      end
      S_SYNCED: begin
        // sync word carries the desync bit, so it is tested first
        if (accept) begin
          if (wr.WriteData == SyncWord) begin
            state_d = S_SYNCED;
          end else if (cmd_desync) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
          end else if (idx_bad) begin
            err_d = 1'b1;
          end else begin
            sel_d   = FrameSelectWidth'(cmd_col);
            idx_d   = cmd_idx;
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d = wr.WriteData;
          dv_d   = 1'b1;
          if (cnt_q == LastRow) begin
            cnt_d   = '0;
            state_d = S_STROBE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      S_STROBE: begin
        state_d = S_SYNCED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sel_q    <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      rdy_q    <= 1'b1;
      synced_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      rdy_q    <= (state_d != S_STROBE);
      synced_q <= (state_d != S_IDLE);
      strobe_q <= (state_d == S_STROBE);
    end
  end

  frame_index_decoder #(
    .N (MaxFramesPerCol),
    .W (IDX_W)
  ) u_dec (
    .clk_i    (CLK),
    .rst_i    (reset),
    .en_i     (state_d == S_STROBE),
    .idx_i    (idx_d),
    .onehot_o (FrameStrobe_O)
  );

  assign wr.WriteReady  = rdy_q;
  assign FrameData      = data_q;
  assign FrameDataValid = dv_q;
  assign FrameSelect    = sel_q;
  assign FrameStrobe    = strobe_q;
  assign Synced         = synced_q;
  assign FrameError     = err_q;

endmodule
